// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase (toggle) handshake: synchronizes req_tog, captures
// data_in on each request level change and acknowledges by toggling ack_tog on consume.
module toggle_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             req_tog,
  input  logic [WIDTH-1:0] data_in,
  input  logic             consume,
  output logic             ack_tog,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             err_overrun
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_evt;

  logic [1:0]       state_q,    state_d;
  logic [2:0]       init_cnt_q, init_cnt_d;
  logic             req_prev_q, req_prev_d;
  logic             ack_q,      ack_d;
  logic             valid_q,    valid_d;
  logic             err_q,      err_d;
  logic [WIDTH-1:0] data_q,     data_d;

  // NOTE: sequential state is always written with <=, so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], req_tog};
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign req_evt = req_s ^ req_prev_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves
    // a variable unassigned, which would infer a latch.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    req_prev_d = req_prev_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    err_d      = err_q;
    data_d     = data_q;

    case (state_q)
      ST_INIT: begin
        // Track the synchronizer until it has flushed so a level already
        // present at reset release is absorbed rather than seen as a request.
        req_prev_d = req_s;
        if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
        else                         init_cnt_d = init_cnt_q + 3'd1;
      end
      ST_IDLE: begin
        if (req_evt) begin
          data_d     = data_in;
          valid_d    = 1'b1;
          req_prev_d = req_s;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (req_evt) begin
          err_d      = 1'b1;
          req_prev_d = req_s;
        end
        if (consume) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  assign ack_tog     = ack_q;
  assign data_out    = data_q;
  assign valid       = valid_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: latency, handshake, reset-time request
// suppression, overrun, simultaneous consume/overrun, async reset and glitch rejection.
module tb_toggle_handshake_rx;

  logic       Clk = 1'b0;
  logic       reset;
  logic       req_tog;
  logic [7:0] data_in;
  logic       consume;
  logic       ack_tog;
  logic [7:0] data_out;
  logic       valid;
  logic       err_overrun;

  int n_vec = 0;
  int n_err = 0;

  toggle_handshake_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .req_tog    (req_tog),
    .data_in    (data_in),
    .consume    (consume),
    .ack_tog    (ack_tog),
    .data_out   (data_out),
    .valid      (valid),
    .err_overrun(err_overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (valid !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic do_reset(input logic req_level);
    reset   = 1'b1;
    req_tog = req_level;
    consume = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    reset   = 1'b1;
    req_tog = 1'b0;
    data_in = 8'h00;
    consume = 1'b0;

    // Reset state
    tick(2);
    check("rst_valid", {31'd0, valid},       32'd0);
    check("rst_ack",   {31'd0, ack_tog},     32'd0);
    check("rst_data",  {24'd0, data_out},    32'd0);
    check("rst_err",   {31'd0, err_overrun}, 32'd0);

    // First transfer: valid exactly SYNC_STAGES+1 edges after the change
    reset = 1'b0;
    tick(5);
    req_tog = 1'b1;
    data_in = 8'hA5;
    tick(2);
    check("lat_early_valid", {31'd0, valid}, 32'd0);
    tick(1);
    check("lat_valid",  {31'd0, valid},   32'd1);
    check("xfer1_data", {24'd0, data_out}, 32'hA5);
    check("xfer1_ack",  {31'd0, ack_tog},  32'd0);

    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    check("cons1_valid", {31'd0, valid},   32'd0);
    check("cons1_ack",   {31'd0, ack_tog}, 32'd1);

    // Second transfer on the falling request edge
    req_tog = 1'b0;
    data_in = 8'h3C;
    wait_valid("xfer2_valid", 10);
    check("xfer2_data", {24'd0, data_out}, 32'h3C);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    check("cons2_ack",   {31'd0, ack_tog}, 32'd0);
    check("cons2_valid", {31'd0, valid},   32'd0);

    // Request level present at reset release must not count
    do_reset(1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_valid |= valid;
    end
    check("init_no_valid", {31'd0, seen_valid}, 32'd0);
    check("init_no_ack",   {31'd0, ack_tog},    32'd0);

    // Overrun while holding 8'h11
    req_tog = 1'b0;
    data_in = 8'h11;
    wait_valid("ovr_hold_valid", 10);
    req_tog = 1'b1;
    data_in = 8'h22;
    tick(4);
    check("ovr_err",   {31'd0, err_overrun}, 32'd1);
    check("ovr_data",  {24'd0, data_out},    32'h11);
    check("ovr_valid", {31'd0, valid},       32'd1);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    check("ovr_cons_ack", {31'd0, ack_tog}, 32'd1);
    tick(5);
    check("ovr_no_revalid", {31'd0, valid},       32'd0);
    check("ovr_one_ack",    {31'd0, ack_tog},     32'd1);
    check("ovr_sticky",     {31'd0, err_overrun}, 32'd1);

    // Event and consume on the same edge
    do_reset(1'b1);
    tick(5);
    check("sim_err_clr", {31'd0, err_overrun}, 32'd0);
    req_tog = 1'b0;
    data_in = 8'h44;
    wait_valid("sim_valid", 10);
    req_tog = 1'b1;
    data_in = 8'h55;
    tick(2);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    check("sim_valid0", {31'd0, valid},       32'd0);
    check("sim_ack",    {31'd0, ack_tog},     32'd1);
    check("sim_err",    {31'd0, err_overrun}, 32'd1);
    check("sim_data",   {24'd0, data_out},    32'h44);
    tick(5);
    check("sim_no_revalid", {31'd0, valid},   32'd0);
    check("sim_ack_stable", {31'd0, ack_tog}, 32'd1);

    // Asynchronous reset mid-HOLD
    req_tog = 1'b0;
    data_in = 8'h5A;
    wait_valid("arst_hold_valid", 10);
    #4;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid},       32'd0);
    check("arst_ack",   {31'd0, ack_tog},     32'd0);
    check("arst_data",  {24'd0, data_out},    32'd0);
    check("arst_err",   {31'd0, err_overrun}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(6);

    // 1 ns glitch between edges is never sampled
    @(posedge Clk);
    #3 req_tog = 1'b1;
    #1 req_tog = 1'b0;
    tick(6);
    check("glitch_valid", {31'd0, valid},   32'd0);
    check("glitch_ack",   {31'd0, ack_tog}, 32'd0);

    // Block still works after the glitch
    req_tog = 1'b1;
    data_in = 8'hC3;
    wait_valid("post_valid", 10);
    check("post_data", {24'd0, data_out}, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
